// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared types and constants for the glitch sequencer
package glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int TRIG_RISE = 0;
  localparam int TRIG_FALL = 1;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_PCNT_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/trig_sync.sv
// rtl/trig_sync.sv - trigger synchroniser with registered edge-select detector
module trig_sync
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TRIG_EDGE   = TRIG_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic edge_det
);

  // The idle level is the one the selected edge leaves, so reset never fakes an edge.
  localparam logic IDLE_LVL = (TRIG_EDGE == TRIG_FALL);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync     <= {SYNC_STAGES{IDLE_LVL}};
      prev     <= IDLE_LVL;
      edge_det <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], trigger};
      prev     <= sync[SYNC_STAGES-1];
      edge_det <= (sync[SYNC_STAGES-1] != prev) && (sync[SYNC_STAGES-1] != IDLE_LVL);
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - armed, triggered burst generator for the glitch output driver
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PCNT_W      = DEF_PCNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TRIG_EDGE   = TRIG_RISE,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [PCNT_W-1:0] cfg_count,
  output logic              glitch,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] pulse_idx
);

  localparam logic              ACT_LVL  = (ACTIVE_HIGH != 0);
  localparam logic              INACT    = ~ACT_LVL;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PIDX_ONE = PCNT_W'(1);

  state_t            state;
  logic              edge_det;
  logic [CNT_W-1:0]  lat_delay;
  logic [CNT_W-1:0]  lat_width;
  logic [CNT_W-1:0]  lat_gap;
  logic [PCNT_W-1:0] lat_count;
  logic [CNT_W-1:0]  phase_cnt;
  logic [CNT_W-1:0]  width_cnt;

  trig_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .TRIG_EDGE  (TRIG_EDGE)
  ) u_trig_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (trigger),
    .edge_det(edge_det)
  );

  // Down-counters are loaded on phase entry and the phase ends when they read 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      glitch    <= INACT;
      armed     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
      lat_delay <= '0;
      lat_width <= '0;
      lat_gap   <= '0;
      lat_count <= '0;
      phase_cnt <= '0;
      width_cnt <= '0;
    end else if (abort) begin
      state  <= ST_IDLE;
      glitch <= INACT;
      armed  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state     <= ST_ARMED;
            armed     <= 1'b1;
            done      <= 1'b0;
            pulse_idx <= '0;
            lat_delay <= cfg_delay;
            lat_width <= (cfg_width == '0) ? CNT_ONE : cfg_width;
            lat_gap   <= (cfg_gap == '0) ? CNT_ONE : cfg_gap;
            lat_count <= (cfg_count == '0) ? PIDX_ONE : cfg_count;
          end
        end
        ST_ARMED: begin
          if (edge_det) begin
            armed <= 1'b0;
            busy  <= 1'b1;
            if (lat_delay == '0) begin
              state     <= ST_PULSE;
              glitch    <= ACT_LVL;
              width_cnt <= lat_width;
            end else begin
              state     <= ST_DELAY;
              phase_cnt <= lat_delay;
            end
          end
        end
        ST_DELAY: begin
          if (phase_cnt == CNT_ONE) begin
            state     <= ST_PULSE;
            glitch    <= ACT_LVL;
            width_cnt <= lat_width;
          end else begin
            phase_cnt <= phase_cnt - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (width_cnt == CNT_ONE) begin
            glitch <= INACT;
            if (pulse_idx == lat_count - PIDX_ONE) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_GAP;
              phase_cnt <= lat_gap;
            end
          end else begin
            width_cnt <= width_cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (phase_cnt == CNT_ONE) begin
            state     <= ST_PULSE;
            glitch    <= ACT_LVL;
            width_cnt <= lat_width;
            pulse_idx <= pulse_idx + PIDX_ONE;
          end else begin
            phase_cnt <= phase_cnt - CNT_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          glitch <= INACT;
          armed  <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - scoreboard bench for glitch_sequencer
module tb_glitch_sequencer;
  import glitch_pkg::*;

  localparam int CW = 32;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, arm_a, arm_b, abort, trig_a, trig_b;
  logic [CW-1:0] cfg_delay, cfg_width, cfg_gap;
  logic [PW-1:0] cfg_count;
  logic          glitch_a, armed_a, busy_a, done_a;
  logic          glitch_b, armed_b, busy_b, done_b;
  logic [PW-1:0] pidx_a, pidx_b;

  glitch_sequencer #(.CNT_W(CW), .PCNT_W(PW), .SYNC_STAGES(2), .TRIG_EDGE(TRIG_RISE), .ACTIVE_HIGH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .arm(arm_a), .abort(abort), .trigger(trig_a),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
    .glitch(glitch_a), .armed(armed_a), .busy(busy_a), .done(done_a), .pulse_idx(pidx_a)
  );

  glitch_sequencer #(.CNT_W(CW), .PCNT_W(PW), .SYNC_STAGES(3), .TRIG_EDGE(TRIG_FALL), .ACTIVE_HIGH(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm(arm_b), .abort(abort), .trigger(trig_b),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
    .glitch(glitch_b), .armed(armed_b), .busy(busy_b), .done(done_b), .pulse_idx(pidx_b)
  );

  typedef struct { int dut; int start; int width; int idx; } pulse_t;
  typedef struct { int dut; int at; } done_t;

  pulse_t pq[$];
  done_t  dq[$];
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  bit     aprev[2];
  bit     dprev[2];
  int     st[2];
  int     sidx[2];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every completed pulse and every done rise is matched against the queues.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit     act;
      bit     dn;
      int     idx;
      pulse_t e;
      done_t  f;
      act = (d == 0) ? glitch_a : !glitch_b;
      dn  = (d == 0) ? done_a : done_b;
      idx = (d == 0) ? int'(pidx_a) : int'(pidx_b);
      if (act && !aprev[d]) begin
        st[d]   = cyc;
        sidx[d] = idx;
      end
      if (!act && aprev[d]) begin
        if (pq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: dut %0d start %0d width %0d, none expected", d, st[d], cyc - st[d]);
        end else begin
          e = pq.pop_front();
          check("pulse_dut", d, e.dut);
          check("pulse_start", st[d], e.start);
          check("pulse_width", cyc - st[d], e.width);
          check("pulse_idx", sidx[d], e.idx);
        end
      end
      if (dn && !dprev[d]) begin
        if (dq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: dut %0d at %0d, none expected", d, cyc);
        end else begin
          f = dq.pop_front();
          check("done_dut", d, f.dut);
          check("done_cycle", cyc, f.at);
        end
      end
      aprev[d] = act;
      dprev[d] = dn;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm(input int d, input int dl, input int w, input int g, input int c);
    @(negedge clk);
    cfg_delay = CW'(dl);
    cfg_width = CW'(w);
    cfg_gap   = CW'(g);
    cfg_count = PW'(c);
    if (d == 0) arm_a = 1'b1;
    else        arm_b = 1'b1;
    @(negedge clk);
    arm_a = 1'b0;
    arm_b = 1'b0;
    cfg_delay = 32'd7;
    cfg_width = 32'd7;
    cfg_gap   = 32'd7;
    cfg_count = 8'd7;
  endtask

  task automatic fire(input int d, input logic lvl, output int e);
    @(negedge clk);
    if (d == 0) trig_a = lvl;
    else        trig_b = lvl;
    e = cyc + 1 + ((d == 0) ? 2 : 3);
  endtask

  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queues_empty", pq.size() + dq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n = 1'b0; arm_a = 1'b0; arm_b = 1'b0; abort = 1'b0;
    trig_a = 1'b0; trig_b = 1'b1;
    cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      trig_a = ~trig_a;
      trig_b = ~trig_b;
    end
    check("rst_glitch_a", glitch_a, 0);
    check("rst_armed_a", armed_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_pidx_a", pidx_a, 0);
    check("rst_glitch_b", glitch_b, 1);
    @(negedge clk);
    trig_a = 1'b0;
    trig_b = 1'b1;
    rst_n  = 1'b1;
    idle(5);

    // single pulse: D=10 W=5 count=1
    do_arm(0, 10, 5, 7, 1);
    check("single_armed", armed_a, 1);
    fire(0, 1'b1, e);
    pq.push_back('{0, e + 11, 5, 0});
    dq.push_back('{0, e + 16});
    wait_cyc(e);
    check("single_busy_at_e", busy_a, 0);
    wait_cyc(e + 1);
    check("single_busy_at_e1", busy_a, 1);
    check("single_armed_at_e1", armed_a, 0);
    drain(100);
    check("single_done_hold", done_a, 1);

    // burst re-armed from DONE: D=0 W=3 G=2 count=4
    fire(0, 1'b0, e);
    do_arm(0, 0, 3, 2, 4);
    check("burst_armed", armed_a, 1);
    check("burst_done_cleared", done_a, 0);
    fire(0, 1'b1, e);
    for (int k = 0; k < 4; k++) pq.push_back('{0, e + 1 + 5 * k, 3, k});
    dq.push_back('{0, e + 19});
    drain(100);
    check("burst_last_idx", pidx_a, 3);

    // zero width/gap/count become 1
    fire(0, 1'b0, e);
    do_arm(0, 2, 0, 0, 0);
    fire(0, 1'b1, e);
    pq.push_back('{0, e + 3, 1, 0});
    dq.push_back('{0, e + 4});
    drain(100);

    // arm during DELAY is ignored
    fire(0, 1'b0, e);
    do_arm(0, 20, 2, 5, 1);
    fire(0, 1'b1, e);
    pq.push_back('{0, e + 21, 2, 0});
    dq.push_back('{0, e + 23});
    wait_cyc(e + 4);
    do_arm(0, 1, 9, 3, 3);
    check("delay_arm_armed", armed_a, 0);
    check("delay_arm_busy", busy_a, 1);
    drain(100);

    // trigger edge in the same cycle as arm is ignored
    fire(0, 1'b0, e);
    idle(3);
    fire(0, 1'b1, e);
    wait_cyc(e - 1);
    do_arm(0, 0, 4, 1, 1);
    idle(5);
    check("same_cycle_armed", armed_a, 1);
    check("same_cycle_busy", busy_a, 0);
    fire(0, 1'b0, e);
    idle(3);
    fire(0, 1'b1, e);
    pq.push_back('{0, e + 1, 4, 0});
    dq.push_back('{0, e + 5});
    drain(100);

    // abort at the 20th active cycle of a W=100 pulse, with a simultaneous arm
    fire(0, 1'b0, e);
    do_arm(0, 0, 100, 1, 1);
    fire(0, 1'b1, e);
    pq.push_back('{0, e + 1, 20, 0});
    wait_cyc(e + 19);
    @(negedge clk);
    abort = 1'b1;
    arm_a = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    arm_a = 1'b0;
    check("abort_glitch", glitch_a, 0);
    check("abort_armed", armed_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    drain(10);
    fire(0, 1'b0, e);
    idle(3);
    fire(0, 1'b1, e);
    idle(30);
    check("post_abort_busy", busy_a, 0);
    check("post_abort_glitch", glitch_a, 0);

    // falling-edge, active-low instance: D=3 W=2 G=1 count=2
    do_arm(1, 3, 2, 1, 2);
    check("b_armed", armed_b, 1);
    check("b_idle_level", glitch_b, 1);
    fire(1, 1'b0, e);
    pq.push_back('{1, e + 4, 2, 0});
    pq.push_back('{1, e + 7, 2, 1});
    dq.push_back('{1, e + 9});
    drain(100);
    check("b_end_level", glitch_b, 1);
    check("b_done", done_b, 1);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
